// File: rtl/mem_responder_pkg.sv
// Shared interface codes, widths and responder state encoding for the memory responder.
package mem_responder_pkg;

    localparam int unsigned IOSTATEWIDTH = 2;
    localparam int unsigned ADDRWIDTH    = 8;
    localparam int unsigned WORDWIDTH    = 8;

    // Request codes on rwToMem; 2'b11 is the illegal fourth code.
    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'b00;
    localparam logic [IOSTATEWIDTH-1:0] RD   = 2'b01;
    localparam logic [IOSTATEWIDTH-1:0] WT   = 2'b10;
    localparam logic [IOSTATEWIDTH-1:0] ILL  = 2'b11;

    localparam int unsigned RSP_STATEWIDTH = 2;

    typedef enum logic [RSP_STATEWIDTH-1:0] {
        RSP_IDLE = 2'b00,
        RSP_WAIT = 2'b01,
        RSP_ACK  = 2'b10
    } rsp_state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage with a synchronous write port and a combinational, range-checked read port.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDRWIDTH-1:0] addr_i,
    input  logic [WORDWIDTH-1:0] wdata_i,
    output logic [WORDWIDTH-1:0] rdata_o,
    output logic                 in_range_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORDWIDTH-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]      idx;

    assign in_range_o = (32'(addr_i) < DEPTH);
    assign idx        = addr_i[IdxW-1:0];

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i && in_range_o) begin
            mem_q[idx] <= wdata_i;
        end
    end

    assign rdata_o = in_range_o ? mem_q[idx] : '0;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one request, waits LATENCY cycles, then holds the
// completion enable until the requester returns to IDEL.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rwToMem,
    input  logic [ADDRWIDTH-1:0]    addrToMem,
    input  logic [WORDWIDTH-1:0]    dataToMem,
    output logic                    rdEn,
    output logic                    wtEn,
    output logic [WORDWIDTH-1:0]    dataFromMem,
    output logic                    busy,
    output logic                    err
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDRWIDTH)) begin : g_bad_depth
        $error("mem_responder: DEPTH must be in 1..2**ADDRWIDTH");
    end

    localparam logic [3:0] LatM1 = 4'(LATENCY - 1);

    rsp_state_e           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 is_wt_q, is_wt_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [WORDWIDTH-1:0] wdata_q, wdata_d;
    logic [WORDWIDTH-1:0] rdata_q, rdata_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wt_en_q, wt_en_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 mem_we;
    logic [WORDWIDTH-1:0] mem_rdata;
    logic                 addr_ok;
    logic                 req_valid;

    assign req_valid = (rwToMem == RD) || (rwToMem == WT);

    mem_array #(
        .DEPTH(DEPTH)
    ) u_mem_array (
        .clk_i     (clk),
        .we_i      (mem_we),
        .addr_i    (addr_q),
        .wdata_i   (wdata_q),
        .rdata_o   (mem_rdata),
        .in_range_o(addr_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
            is_wt_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_en_q <= 1'b0;
            wt_en_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wt_q <= is_wt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_en_q <= rd_en_d;
            wt_en_q <= wt_en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RSP_IDLE: if (req_valid) state_d = RSP_WAIT;
            RSP_WAIT: begin
                if (rwToMem == IDEL) begin
                    state_d = RSP_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RSP_ACK;
                end
            end
            RSP_ACK:  if (rwToMem == IDEL) state_d = RSP_IDLE;
            default:  state_d = RSP_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        is_wt_d = is_wt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_en_d = rd_en_q;
        wt_en_d = wt_en_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        busy_d  = (state_d != RSP_IDLE);
        unique case (state_q)
            RSP_IDLE: begin
                if (req_valid) begin
                    is_wt_d = (rwToMem == WT);
                    addr_d  = addrToMem;
                    wdata_d = dataToMem;
                    cnt_d   = LatM1;
                end else if (rwToMem == ILL) begin
                    err_d = 1'b1;
                end
            end
            RSP_WAIT: begin
                if (rwToMem != IDEL) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        // Access uses only the latched request; live inputs are ignored here.
                        if (is_wt_q) begin
                            mem_we  = 1'b1;
                            wt_en_d = 1'b1;
                        end else begin
                            rd_en_d = 1'b1;
                            rdata_d = mem_rdata;
                        end
                        if (!addr_ok) err_d = 1'b1;
                    end
                end
            end
            RSP_ACK: begin
                if (rwToMem == IDEL) begin
                    rd_en_d = 1'b0;
                    wt_en_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign rdEn        = rd_en_q;
    assign wtEn        = wt_en_q;
    assign dataFromMem = rdata_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the processor memory interface (`rwToMem`, `addrToMem`, `dataToMem`, `rdEn`, `wtEn`, `dataFromMem`).
- Accepts one read or write request at a time and models a word-addressed memory with a fixed, programmable wait-state latency.
- Completes each request with a level handshake: the enable is held until the requester returns to `IDEL`.
- Serves as the system memory behind the processor, and as the bench memory model for processor and cache verification.

Parameters:
- LATENCY, default 3: cycles from request capture to enable assertion. Legal range is 1..15; out of range is a compile-time error.
- DEPTH, default 16: number of words stored. Valid addresses are 0..DEPTH-1; DEPTH must be no greater than 2**`ADDRWIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rwToMem  in  `IOSTATEWIDTH  request code: `IDEL`, `RD` or `WT`; the fourth code is illegal.
- addrToMem  in  `ADDRWIDTH  word address of the request.
- dataToMem  in  `WORDWIDTH  write data.
- rdEn  out  1  read complete; `dataFromMem` is valid while high.
- wtEn  out  1  write committed.
- dataFromMem  out  `WORDWIDTH  read data.
- busy  out  1  high in WAIT and ACK.
- err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rdEn=0, wtEn=0, dataFromMem=0, busy=0, err=0; counter=0.
  - Array contents are not reset.
  - Asserting reset mid-transaction aborts it; a write still in WAIT is not committed.
- States: IDLE, WAIT, ACK, encoded 2 bits.
- IDLE:
  - On an edge sampling rwToMem=`RD` or `WT`: latch op, addrToMem and dataToMem; load counter=LATENCY-1; go to WAIT.
  - On an edge sampling the illegal code: set err=1 and stay in IDLE.
  - `IDEL`: no action.
- WAIT:
  - If rwToMem is sampled as `IDEL`: abort, go to IDLE, no array access, no enable.
  - Else if counter != 0: decrement.
  - Else (counter == 0): perform the access using the latched op, address and data; go to ACK.
    - Read: dataFromMem=mem[addr], rdEn=1.
    - Write: mem[addr]=data, wtEn=1.
  - Changes to rwToMem (other than to `IDEL`), addrToMem or dataToMem during WAIT are ignored.
- Latency: with the request first sampled at edge T0, the enable is high from just after edge T0+LATENCY.
- ACK:
  - rdEn/wtEn and dataFromMem are held stable.
  - On the first edge sampling rwToMem=`IDEL`: clear rdEn, wtEn and busy; go to IDLE.
  - dataFromMem keeps its last value; it is not cleared.
  - A new request needs at least one sampled `IDEL` cycle; back-to-back requests without `IDEL` are never accepted.
- busy = (state != IDLE), registered.
- Out-of-range address (addr >= DEPTH):
  - The handshake completes normally.
  - A read returns 0; a write is discarded.
  - err is set on entry to ACK.
- rdEn and wtEn are never high together; enables are exactly one-hot or zero.
- err clears only on reset.

Decomposition:
- def.v (shared) holds:
  - `IOSTATEWIDTH` and the `IDEL`/`RD`/`WT` codes;
  - `ADDRWIDTH` and `WORDWIDTH`;
  - the new responder state codes RSP_IDLE, RSP_WAIT, RSP_ACK and RSP_STATEWIDTH.
- One sub-module, mem_array:
  - DEPTH x `WORDWIDTH` storage;
  - synchronous write-enable port and combinational read port;
  - in-range check, with out-of-range reads returning 0.
- The FSM, counter, latches and flags live in mem_responder.

Test Plan:
- LATENCY=3: WT addr 5, data 0xA5 at T0, held to the enable, then IDEL → wtEn high from T0+3, cleared one cycle after IDEL is sampled; busy pulses for the whole transaction.
- Then RD addr 5 → rdEn high from T0+3 with dataFromMem=0xA5, held stable while RD is held 4 extra cycles; then IDEL → rdEn low, dataFromMem still 0xA5.
- WT addr 7, data 0x3C, then drop to IDEL after 1 cycle of WAIT → no wtEn, return to IDLE; a later RD addr 7 returns the pre-existing value, not 0x3C.
- RD addr DEPTH (16) → handshake completes, dataFromMem=0, err=1 and stays 1 across subsequent good transactions; a WT to addr 16 does not alias into addr 0.
- Illegal rwToMem code for 1 cycle in IDLE → err=1, no enable, busy stays 0; change dataToMem and addrToMem during WAIT of a WT → the originally latched address and data are written.
- Assert reset low mid-WAIT of WT addr 2, data 0x11 → outputs 0 immediately (asynchronously); after release, RD addr 2 does not return 0x11.
